pipe_ctrl: RTL and testbench

Central stall/flush/redirect controller for the 5-stage pipeline.
- Merges stall requests from IF, ID, EX and MEM into a per-stage stall vector. Bit 0 drives the PC register's write-hold input.
- Sequences PC redirection for taken branches and exceptions. Holds a branch target while the PC is frozen.
- Watchdog: flags stalls that persist for too long.

---
 rtl/pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall / flush / redirect controller for the 5-stage pipeline.
//
// Merges per-stage stall requests into one stall vector, sequences PC
// redirection for taken branches and exceptions, and runs a watchdog on
// long stalls.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   stallreq_if_i       fetch wait
//   stallreq_id_i       load-use hazard
//   stallreq_ex_i       multi-cycle EX op busy
//   stallreq_mem_i      data memory wait
//   branch_flag_i       taken branch resolved in ID (one-cycle pulse)
//   branch_target_i     branch target, valid with branch_flag_i
//   exc_flag_i          exception committed in MEM
//   stall_o             per-stage hold {wb,mem,ex,id,if,pc}
//   flush_o             clear all pipeline registers (exceptions only)
//   pc_redirect_o       next PC := pc_target_o (combinational)
//   pc_target_o         redirect address
//   stall_timeout_o     watchdog flag (registered)
//   dbg_state_o         1 while a branch target is parked (HOLD_BR)
//
// Handshake: pc_redirect_o/pc_target_o are a zero-latency request to the PC
// mux; the PC loads the target on the next clk edge. A redirect is never
// raised while stall_o[0] holds the PC, so it is always accepted.
module pipe_ctrl #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(32'h0000_0020),
    parameter int                STALL_TMO  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if_i,
    input  logic              stallreq_id_i,
    input  logic              stallreq_ex_i,
    input  logic              stallreq_mem_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              exc_flag_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic              pc_redirect_o,
    output logic [ADDR_W-1:0] pc_target_o,
    output logic              stall_timeout_o,
    output logic              dbg_state_o
);

    typedef enum logic {
        RUN     = 1'b0,
        HOLD_BR = 1'b1
    } state_t;

    localparam logic [15:0] TMO = 16'(STALL_TMO);

    state_t            r_state;
    logic [ADDR_W-1:0] r_br_tgt;
    logic [15:0]       r_stall_cnt;
    logic              r_timeout;

    logic [5:0]        w_stall;
    logic              w_hold_pc;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic [15:0]       w_cnt_next;

    // Stall vector: a request from a stage holds that stage and everything
    // upstream of it. An exception overrides all stalls so the flush and
    // redirect take effect immediately.
    always_comb begin
        w_stall = 6'b000000;
        if (!rst && !exc_flag_i) begin
            if (stallreq_mem_i)     w_stall = 6'b011111;
            else if (stallreq_ex_i) w_stall = 6'b001111;
            else if (stallreq_id_i) w_stall = 6'b000111;
            else if (stallreq_if_i) w_stall = 6'b000011;
        end
    end

    assign w_hold_pc = w_stall[0];

    // Redirect request. A fresh branch in the HOLD_BR exit cycle is younger
    // than the parked target, so it takes precedence.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = '0;
        if (!rst) begin
            if (exc_flag_i) begin
                w_redirect = 1'b1;
                w_target   = EXC_VECTOR;
            end else if (!w_hold_pc) begin
                if (branch_flag_i) begin
                    w_redirect = 1'b1;
                    w_target   = branch_target_i;
                end else if (r_state == HOLD_BR) begin
                    w_redirect = 1'b1;
                    w_target   = r_br_tgt;
                end
            end
        end
    end

    // Watchdog counter: saturating, cleared by any unstalled cycle (which
    // includes every exception cycle, since exceptions zero the vector).
    always_comb begin
        if (w_stall == 6'b000000)       w_cnt_next = 16'd0;
        else if (r_stall_cnt == 16'hFFFF) w_cnt_next = r_stall_cnt;
        else                            w_cnt_next = r_stall_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_br_tgt    <= '0;
            r_stall_cnt <= 16'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_stall_cnt <= w_cnt_next;
            r_timeout   <= (w_cnt_next >= TMO);
            if (exc_flag_i) begin
                r_state  <= RUN;
                r_br_tgt <= '0;
            end else begin
                case (r_state)
                    RUN: begin
                        if (branch_flag_i && w_hold_pc) begin
                            r_br_tgt <= branch_target_i;
                            r_state  <= HOLD_BR;
                        end
                    end
                    HOLD_BR: begin
                        if (w_hold_pc) begin
                            if (branch_flag_i) r_br_tgt <= branch_target_i;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                    default: r_state <= RUN;
                endcase
            end
        end
    end

    assign stall_o         = w_stall;
    assign flush_o         = !rst && exc_flag_i;
    assign pc_redirect_o   = w_redirect;
    assign pc_target_o     = w_target;
    assign stall_timeout_o = r_timeout;
    assign dbg_state_o     = (r_state == HOLD_BR);

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  localparam int TMO = 4;
  localparam logic [31:0] EXC_V = 32'h0000_0020;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sif, sid, sex, smem, br, exc;
  logic [31:0] bt;
  logic [5:0]  stall_o;
  logic        flush_o, pc_redirect_o, stall_timeout_o, dbg_state_o;
  logic [31:0] pc_target_o;

  pipe_ctrl #(.ADDR_W(32), .EXC_VECTOR(EXC_V), .STALL_TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(sif), .stallreq_id_i(sid), .stallreq_ex_i(sex), .stallreq_mem_i(smem),
    .branch_flag_i(br), .branch_target_i(bt), .exc_flag_i(exc),
    .stall_o(stall_o), .flush_o(flush_o), .pc_redirect_o(pc_redirect_o),
    .pc_target_o(pc_target_o), .stall_timeout_o(stall_timeout_o), .dbg_state_o(dbg_state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state: a parked branch, a stall run length, a flag
  logic        m_pend;
  logic [31:0] m_tgt;
  int          m_run;
  logic        m_to;

  // scoreboard of redirect targets the PC should receive
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // number of pipeline stages (from pc upward) held for the current requests
  function automatic int held_stages();
    if (exc)  return 0;
    if (smem) return 5;
    if (sex)  return 4;
    if (sid)  return 3;
    if (sif)  return 2;
    return 0;
  endfunction

  // one clock cycle: inputs already driven; check combinational outputs,
  // advance the model across the edge, then check registered outputs
  task automatic cyc();
    int          n;
    logic [5:0]  e_stall;
    logic        e_redir;
    logic [31:0] e_tgt;
    #1;
    n       = rst ? 0 : held_stages();
    e_stall = 6'((1 << n) - 1);
    e_redir = 1'b0;
    e_tgt   = 32'h0;
    if (!rst) begin
      if (exc) begin
        e_redir = 1'b1; e_tgt = EXC_V;
      end else if (n == 0 && (br || m_pend)) begin
        e_redir = 1'b1; e_tgt = br ? bt : m_tgt;
      end
    end
    if (e_redir) exp_q.push_back(e_tgt);
    check("stall_o", 32'(stall_o), 32'(e_stall));
    check("flush_o", 32'(flush_o), 32'(!rst && exc));
    check("pc_redirect_o", 32'(pc_redirect_o), 32'(e_redir));
    if (pc_redirect_o && exp_q.size() > 0) check("pc_target_o", pc_target_o, exp_q.pop_front());
    else if (rst) check("pc_target_o_rst", pc_target_o, 32'h0);
    exp_q.delete();
    @(posedge clk);
    if (rst) begin
      m_pend = 1'b0; m_tgt = 32'h0; m_run = 0; m_to = 1'b0;
    end else begin
      if (exc) begin
        m_pend = 1'b0;
      end else if (n > 0) begin
        if (br) begin m_pend = 1'b1; m_tgt = bt; end
      end else begin
        m_pend = 1'b0;
      end
      m_run = (n > 0) ? ((m_run < 65535) ? m_run + 1 : 65535) : 0;
      m_to  = (m_run >= TMO);
    end
    #1;
    check("stall_timeout_o", 32'(stall_timeout_o), 32'(m_to));
    check("hold_br_state", 32'(dbg_state_o), 32'(m_pend));
  endtask

  task automatic drive(input logic r, input logic i_f, input logic i_d, input logic i_e,
                       input logic i_m, input logic b, input logic [31:0] t, input logic x);
    rst = r; sif = i_f; sid = i_d; sex = i_e; smem = i_m; br = b; bt = t; exc = x;
  endtask

  initial begin
    int burst;
    m_pend = 1'b0; m_tgt = 32'h0; m_run = 0; m_to = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 1);
    cyc();
    cyc();
    // reset released, idle
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    check("idle_stall", 32'(stall_o), 32'h0);
    // priority merge
    drive(0, 0, 1, 0, 1, 0, 32'h0, 0);
    #1 check("id_mem_stall", 32'(stall_o), 32'h1F);
    cyc();
    drive(0, 0, 1, 0, 0, 0, 32'h0, 0);
    #1 check("id_stall", 32'(stall_o), 32'h07);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    // branch without stall: same-cycle redirect
    drive(0, 0, 0, 0, 0, 1, 32'h0000_0100, 0);
    #1 check("br_now_target", pc_target_o, 32'h100);
    cyc();
    // branch parked under a 3-cycle fetch stall
    drive(0, 1, 0, 0, 0, 1, 32'h0000_0200, 0);
    cyc();
    drive(0, 1, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    cyc();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    #1 check("br_held_target", pc_target_o, 32'h200);
    cyc();
    check("back_in_run", 32'(dbg_state_o), 32'h0);
    // exception while a branch is parked
    drive(0, 0, 0, 1, 0, 1, 32'h0000_0300, 0);
    cyc();
    drive(0, 0, 0, 1, 0, 1, 32'h0000_0340, 1);
    #1 check("exc_target", pc_target_o, 32'h20);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    // watchdog: ex stall held 6 cycles
    drive(0, 0, 0, 1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 6; i++) cyc();
    check("tmo_high", 32'(stall_timeout_o), 32'h1);
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    check("tmo_low", 32'(stall_timeout_o), 32'h0);
    // reset while a branch is parked
    drive(0, 0, 1, 0, 0, 1, 32'h0000_0400, 0);
    cyc();
    drive(1, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 32'h0, 0);
    cyc();
    // randomized traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst == 0 && $urandom_range(0, 40) == 0) burst = $urandom_range(3, 9);
      drive($urandom_range(0, 300) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            (burst > 0) || ($urandom_range(0, 6) == 0), $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 25) == 0);
      if (burst > 0) burst--;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
